// File: rtl/anita4_trig_pulse_tx_if.sv
// Trigger-line transmitter bundle: request/config inputs and registered line/counter outputs.
// Signal names match the original port list so existing wiring maps one-to-one.
interface anita4_trig_pulse_tx_if #(
  parameter int WIDTH_BITS = 8,
  parameter int HOLD_BITS  = 8,
  parameter int CNT_BITS   = 16
);
  logic                  TRIG_REQ;
  logic                  MASK;
  logic [WIDTH_BITS-1:0] PULSE_WIDTH;
  logic [HOLD_BITS-1:0]  HOLDOFF;
  logic                  CNT_CLEAR;
  logic                  TRIG_OUT;
  logic                  RX_CLR;
  logic                  BUSY;
  logic [CNT_BITS-1:0]   TRIG_COUNT;
  logic [CNT_BITS-1:0]   DROP_COUNT;

  modport master (
    output TRIG_REQ, MASK, PULSE_WIDTH, HOLDOFF, CNT_CLEAR,
    input  TRIG_OUT, RX_CLR, BUSY, TRIG_COUNT, DROP_COUNT
  );

  modport slave (
    input  TRIG_REQ, MASK, PULSE_WIDTH, HOLDOFF, CNT_CLEAR,
    output TRIG_OUT, RX_CLR, BUSY, TRIG_COUNT, DROP_COUNT
  );
endinterface

// File: rtl/anita4_trig_pulse_tx.sv
// Single-pol trigger transmitter: turns 1-cycle requests into an active-low pulse,
// re-arms the far-end latch via RX_CLR, enforces holdoff, counts sent/dropped triggers.
module anita4_trig_pulse_tx #(
  parameter int WIDTH_BITS   = 8,
  parameter int HOLD_BITS    = 8,
  parameter int CNT_BITS     = 16,
  parameter int REARM_CYCLES = 2
) (
  input  logic CLK,
  input  logic CLR_N,
  anita4_trig_pulse_tx_if.slave io
);

  localparam int TW_WH = (WIDTH_BITS > HOLD_BITS) ? WIDTH_BITS : HOLD_BITS;
  localparam int TW_RC = $clog2(REARM_CYCLES + 1);
  localparam int TW    = (TW_WH > TW_RC) ? TW_WH : TW_RC;

  localparam logic [TW-1:0]         TW_ONE     = 1;
  localparam logic [WIDTH_BITS-1:0] PW_ONE     = 1;
  localparam logic [HOLD_BITS-1:0]  HO_ONE     = 1;
  localparam logic [CNT_BITS-1:0]   CNT_ONE    = 1;
  localparam logic [TW-1:0]         REARM_LOAD = TW'(REARM_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PULSE,
    ST_REARM,
    ST_HOLD
  } state_e;

  state_e                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [HOLD_BITS-1:0]  ho_q, ho_d;
  logic                  trig_out_q, trig_out_d;
  logic                  rx_clr_q, rx_clr_d;
  logic                  busy_q, busy_d;
  logic [CNT_BITS-1:0]   trig_cnt_q, trig_cnt_d;
  logic [CNT_BITS-1:0]   drop_cnt_q, drop_cnt_d;

  logic                  req_live;
  logic                  accept;
  logic                  drop;
  logic [WIDTH_BITS-1:0] pw_m1;
  logic [HOLD_BITS-1:0]  ho_m1;

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      ho_q       <= '0;
      trig_out_q <= 1'b1;
      rx_clr_q   <= 1'b1;
      busy_q     <= 1'b0;
      trig_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      ho_q       <= ho_d;
      trig_out_q <= trig_out_d;
      rx_clr_q   <= rx_clr_d;
      busy_q     <= busy_d;
      trig_cnt_q <= trig_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // timer_q holds "cycles remaining minus one" in the current timed state
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    ho_d     = ho_q;
    req_live = io.TRIG_REQ & ~io.MASK;
    accept   = req_live & (state_q == ST_IDLE);
    drop     = req_live & (state_q != ST_IDLE);
    pw_m1    = (io.PULSE_WIDTH == '0) ? '0 : io.PULSE_WIDTH - PW_ONE;
    ho_m1    = ho_q - HO_ONE;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_PULSE;
          timer_d = TW'(pw_m1);
          ho_d    = io.HOLDOFF;
        end
      end
      ST_PULSE: begin
        if (timer_q == '0) begin
          state_d = ST_REARM;
          timer_d = REARM_LOAD;
        end else begin
          timer_d = timer_q - TW_ONE;
        end
      end
      ST_REARM: begin
        if (timer_q == '0) begin
          if (ho_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLD;
            timer_d = TW'(ho_m1);
          end
        end else begin
          timer_d = timer_q - TW_ONE;
        end
      end
      ST_HOLD: begin
        if (timer_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - TW_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line outputs are decoded from the next state so they change on the same edge
    trig_out_d = (state_d != ST_PULSE);
    rx_clr_d   = (state_d == ST_REARM);
    busy_d     = (state_d != ST_IDLE);
  end

  always_comb begin
    trig_cnt_d = trig_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (io.CNT_CLEAR) begin
      trig_cnt_d = '0;
      drop_cnt_d = '0;
    end else begin
      if (accept) begin
        trig_cnt_d = trig_cnt_q + CNT_ONE;
      end
      if (drop && (drop_cnt_q != '1)) begin
        drop_cnt_d = drop_cnt_q + CNT_ONE;
      end
    end
  end

  assign io.TRIG_OUT   = trig_out_q;
  assign io.RX_CLR     = rx_clr_q;
  assign io.BUSY       = busy_q;
  assign io.TRIG_COUNT = trig_cnt_q;
  assign io.DROP_COUNT = drop_cnt_q;

endmodule

// File: tb/tb_anita4_trig_pulse_tx.sv
// Directed bench for anita4_trig_pulse_tx: per-cycle vector table plus hand sequences
// for counter clear, async reset mid-pulse and drop-counter saturation.
module tb_anita4_trig_pulse_tx;

  logic CLK;
  logic CLR_N;
  int   n_cmp;
  int   n_bad;

  anita4_trig_pulse_tx_if #(.WIDTH_BITS(8), .HOLD_BITS(8), .CNT_BITS(16)) bus ();
  anita4_trig_pulse_tx_if #(.WIDTH_BITS(8), .HOLD_BITS(8), .CNT_BITS(4))  sbus ();

  anita4_trig_pulse_tx #(
    .WIDTH_BITS(8), .HOLD_BITS(8), .CNT_BITS(16), .REARM_CYCLES(2)
  ) u_dut (
    .CLK  (CLK),
    .CLR_N(CLR_N),
    .io   (bus)
  );

  // Narrow-counter instance so drop saturation is reachable in a few cycles
  anita4_trig_pulse_tx #(
    .WIDTH_BITS(8), .HOLD_BITS(8), .CNT_BITS(4), .REARM_CYCLES(2)
  ) u_dut_sat (
    .CLK  (CLK),
    .CLR_N(CLR_N),
    .io   (sbus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        req;
    logic        mask;
    logic [7:0]  pw;
    logic [7:0]  ho;
    logic        trig;
    logic        rx;
    logic        busy;
    logic [15:0] tc;
    logic [15:0] dc;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic rq, input logic mk, input int pw, input int ho,
                              input logic t, input logic r, input logic b,
                              input int tc, input int dc);
    vec_t v;
    v.req  = rq;
    v.mask = mk;
    v.pw   = 8'(pw);
    v.ho   = 8'(ho);
    v.trig = t;
    v.rx   = r;
    v.busy = b;
    v.tc   = 16'(tc);
    v.dc   = 16'(dc);
    tbl.push_back(v);
  endfunction

  task automatic check1(input string nm, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b want %0b", nm, got, exp);
    end
  endtask

  task automatic checkn(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, got, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge, return at the following negedge
  task automatic tick(input logic rq, input logic mk, input logic clr);
    @(posedge CLK);
    #1;
    bus.TRIG_REQ  = rq;
    bus.MASK      = mk;
    bus.CNT_CLEAR = clr;
    @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    CLR_N = 1'b0;
    bus.TRIG_REQ = 1'b0;  bus.MASK = 1'b0;  bus.CNT_CLEAR = 1'b0;
    bus.PULSE_WIDTH = 8'd3;  bus.HOLDOFF = 8'd4;
    sbus.TRIG_REQ = 1'b0; sbus.MASK = 1'b0; sbus.CNT_CLEAR = 1'b0;
    sbus.PULSE_WIDTH = 8'd20; sbus.HOLDOFF = 8'd0;

    // req, mask, pw, ho | trig, rx_clr, busy, trig_count, drop_count (row = cycle)
    add(0,0,3,4, 1,0,0,0,0);
    add(0,0,3,4, 1,0,0,0,0);
    add(1,0,3,4, 1,0,0,0,0);
    add(0,0,3,4, 0,0,1,1,0);
    add(1,0,3,4, 0,0,1,1,0);
    add(0,0,3,4, 0,0,1,1,1);
    add(0,0,3,4, 1,1,1,1,1);
    add(0,0,3,4, 1,1,1,1,1);
    for (int i = 0; i < 3; i++) add(0,0,3,4, 1,0,1,1,1);
    add(1,0,3,4, 1,0,1,1,1);
    add(1,0,3,4, 1,0,0,1,2);
    for (int i = 0; i < 3; i++) add(0,0,1,0, 0,0,1,2,2);
    for (int i = 0; i < 2; i++) add(0,0,1,0, 1,1,1,2,2);
    for (int i = 0; i < 4; i++) add(0,0,1,0, 1,0,1,2,2);
    add(0,0,0,0, 1,0,0,2,2);
    add(1,0,0,0, 1,0,0,2,2);
    add(0,0,0,0, 0,0,1,3,2);
    add(0,0,0,0, 1,1,1,3,2);
    add(0,0,0,0, 1,1,1,3,2);
    add(0,0,0,0, 1,0,0,3,2);
    add(1,1,0,0, 1,0,0,3,2);
    add(0,0,3,1, 1,0,0,3,2);
    add(1,0,3,1, 1,0,0,3,2);
    add(0,0,3,1, 0,0,1,4,2);
    add(1,1,3,1, 0,0,1,4,2);
    add(0,1,3,1, 0,0,1,4,2);
    add(0,0,3,1, 1,1,1,4,2);
    add(1,0,3,1, 1,1,1,4,2);
    add(0,0,3,1, 1,0,1,4,3);
    add(0,0,3,1, 1,0,0,4,3);

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check1("rst.trig", bus.TRIG_OUT, 1'b1);
    check1("rst.rxclr", bus.RX_CLR, 1'b1);
    check1("rst.busy", bus.BUSY, 1'b0);
    checkn("rst.tc", bus.TRIG_COUNT, 16'd0);
    checkn("rst.dc", bus.DROP_COUNT, 16'd0);
    @(posedge CLK);
    #1 CLR_N = 1'b1;

    foreach (tbl[i]) begin
      @(posedge CLK);
      #1;
      bus.TRIG_REQ    = tbl[i].req;
      bus.MASK        = tbl[i].mask;
      bus.PULSE_WIDTH = tbl[i].pw;
      bus.HOLDOFF     = tbl[i].ho;
      @(negedge CLK);
      check1($sformatf("row%0d.trig", i), bus.TRIG_OUT, tbl[i].trig);
      check1($sformatf("row%0d.rxclr", i), bus.RX_CLR, tbl[i].rx);
      check1($sformatf("row%0d.busy", i), bus.BUSY, tbl[i].busy);
      checkn($sformatf("row%0d.tc", i), bus.TRIG_COUNT, tbl[i].tc);
      checkn($sformatf("row%0d.dc", i), bus.DROP_COUNT, tbl[i].dc);
    end

    // Clear in the same cycle as an accepted request: counts zero, pulse still sent
    bus.PULSE_WIDTH = 8'd2;
    bus.HOLDOFF     = 8'd0;
    tick(1, 0, 1);
    tick(0, 0, 0);
    check1("clr.trig", bus.TRIG_OUT, 1'b0);
    check1("clr.busy", bus.BUSY, 1'b1);
    checkn("clr.tc", bus.TRIG_COUNT, 16'd0);
    checkn("clr.dc", bus.DROP_COUNT, 16'd0);
    tick(0, 0, 0);
    check1("clr.trig2", bus.TRIG_OUT, 1'b0);
    tick(0, 0, 0);
    check1("clr.trig_end", bus.TRIG_OUT, 1'b1);
    check1("clr.rx1", bus.RX_CLR, 1'b1);
    tick(0, 0, 0);
    check1("clr.rx2", bus.RX_CLR, 1'b1);
    tick(0, 0, 0);
    check1("clr.rx_off", bus.RX_CLR, 1'b0);
    check1("clr.idle", bus.BUSY, 1'b0);
    tick(1, 0, 0);
    tick(0, 0, 0);
    checkn("clr.tc_next", bus.TRIG_COUNT, 16'd1);
    check1("clr.trig_next", bus.TRIG_OUT, 1'b0);

    // Async reset in the middle of that pulse
    CLR_N = 1'b0;
    #1;
    check1("arst.trig", bus.TRIG_OUT, 1'b1);
    check1("arst.rxclr", bus.RX_CLR, 1'b1);
    check1("arst.busy", bus.BUSY, 1'b0);
    checkn("arst.tc", bus.TRIG_COUNT, 16'd0);
    @(posedge CLK);
    #1 CLR_N = 1'b1;
    tick(0, 0, 0);
    check1("arst.rx_rel", bus.RX_CLR, 1'b0);
    check1("arst.trig_rel", bus.TRIG_OUT, 1'b1);
    tick(1, 0, 0);
    tick(0, 0, 0);
    check1("post.trig", bus.TRIG_OUT, 1'b0);
    checkn("post.tc", bus.TRIG_COUNT, 16'd1);
    tick(0, 0, 0);
    check1("post.trig2", bus.TRIG_OUT, 1'b0);
    tick(0, 0, 0);
    check1("post.trig_end", bus.TRIG_OUT, 1'b1);
    check1("post.rx", bus.RX_CLR, 1'b1);
    tick(0, 0, 0);
    tick(0, 0, 0);
    check1("post.idle", bus.BUSY, 1'b0);

    // Held request on the 4-bit instance: one accept, then a drop every busy cycle
    @(posedge CLK);
    #1 sbus.TRIG_REQ = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      checkn($sformatf("sat.dc%0d", k), 16'(sbus.DROP_COUNT), 16'((k > 15) ? 15 : k));
    end
    checkn("sat.tc", 16'(sbus.TRIG_COUNT), 16'd1);
    @(posedge CLK);
    #1 sbus.CNT_CLEAR = 1'b1;
    @(negedge CLK);
    @(posedge CLK);
    #1;
    sbus.CNT_CLEAR = 1'b0;
    sbus.TRIG_REQ  = 1'b0;
    @(negedge CLK);
    checkn("sat.clr_dc", 16'(sbus.DROP_COUNT), 16'd0);
    checkn("sat.clr_tc", 16'(sbus.TRIG_COUNT), 16'd0);
    repeat (10) @(posedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
